// File: rtl/yin_pkg.sv
// Shared definitions for the YIN pitch-lag scheduler: controller states and
// the lag / threshold-fraction widths used across the block.
package yin_pkg;

  localparam int TAU_WIDTH        = 6;
  localparam int THRESH_FRAC_BITS = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    EVAL   = 3'd3,
    FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/yin_cmnd_compare.sv
// Cumulative-mean-normalised difference threshold test:
// hit when S != 0 and d*tau*2^F < threshold*S, evaluated without overflow.
module yin_cmnd_compare #(
  parameter int ACC_WIDTH        = 64,
  parameter int THRESH_FRAC_BITS = 16
) (
  input  logic [ACC_WIDTH-1:0]                      d,
  input  logic [yin_pkg::TAU_WIDTH-1:0]             tau,
  input  logic [ACC_WIDTH+yin_pkg::TAU_WIDTH-1:0]   sum,
  input  logic [THRESH_FRAC_BITS-1:0]               threshold,
  output logic                                      hit
);
  import yin_pkg::*;

  localparam int SUM_W = ACC_WIDTH + TAU_WIDTH;
  localparam int PW    = SUM_W + THRESH_FRAC_BITS;

  logic [PW-1:0] w_lhs;
  logic [PW-1:0] w_rhs;

  // Both sides are widened to the full product width before multiplying.
  always_comb begin
    w_lhs = (PW'(d) * PW'(tau)) << THRESH_FRAC_BITS;
    w_rhs = PW'(threshold) * PW'(sum);
    hit   = (sum != {SUM_W{1'b0}}) && (w_lhs < w_rhs);
  end

endmodule

// File: rtl/yin_tau_scheduler.sv
// Sequences lags 1..MAX_TAU through an external difference datapath and stops
// at the first lag whose normalised difference falls below the threshold.
module yin_tau_scheduler #(
  parameter int WINDOW_SIZE_BITS = 8,
  parameter int ACC_WIDTH        = 64,
  parameter int MAX_TAU          = 40,
  parameter int THRESH_FRAC_BITS = yin_pkg::THRESH_FRAC_BITS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [THRESH_FRAC_BITS-1:0]    threshold,
  output logic [yin_pkg::TAU_WIDTH-1:0]  diff_tau,
  output logic                           diff_reset,
  input  logic                           diff_ready,
  input  logic [ACC_WIDTH-1:0]           diff_acc,
  output logic                           busy,
  output logic                           done,
  output logic                           found,
  output logic [yin_pkg::TAU_WIDTH-1:0]  tau_out
);
  import yin_pkg::*;

  localparam int                   SUM_W     = ACC_WIDTH + TAU_WIDTH;
  localparam logic [TAU_WIDTH-1:0] MAX_TAU_L = MAX_TAU[TAU_WIDTH-1:0];

  state_t                        r_state;
  logic [TAU_WIDTH-1:0]          r_tau;
  logic [SUM_W-1:0]              r_running_sum;
  logic [THRESH_FRAC_BITS-1:0]   r_threshold;

  logic [SUM_W-1:0]              w_sum;
  logic                          w_hit;

  // Running sum including the lag currently being evaluated.
  always_comb begin
    w_sum = r_running_sum + {{TAU_WIDTH{1'b0}}, diff_acc};
  end

  yin_cmnd_compare #(
    .ACC_WIDTH        (ACC_WIDTH),
    .THRESH_FRAC_BITS (THRESH_FRAC_BITS)
  ) u_compare (
    .d         (diff_acc),
    .tau       (r_tau),
    .sum       (w_sum),
    .threshold (r_threshold),
    .hit       (w_hit)
  );

  // Controller FSM; every output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_tau         <= {TAU_WIDTH{1'b0}};
      r_running_sum <= {SUM_W{1'b0}};
      r_threshold   <= {THRESH_FRAC_BITS{1'b0}};
      diff_tau      <= {TAU_WIDTH{1'b0}};
      diff_reset    <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      found         <= 1'b0;
      tau_out       <= {TAU_WIDTH{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          busy       <= 1'b0;
          done       <= 1'b0;
          diff_reset <= 1'b1;
          if (start) begin
            r_state       <= CLEAR;
            r_tau         <= {{(TAU_WIDTH-1){1'b0}}, 1'b1};
            diff_tau      <= {{(TAU_WIDTH-1){1'b0}}, 1'b1};
            r_running_sum <= {SUM_W{1'b0}};
            r_threshold   <= threshold;
            found         <= 1'b0;
            tau_out       <= {TAU_WIDTH{1'b0}};
            busy          <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        CLEAR: begin
          diff_reset <= 1'b0;
          r_state    <= RUN;
        end
        RUN: begin
          // Datapath latency is open-ended; wait for its ready flag.
          if (diff_ready) begin
            diff_reset <= 1'b1;
            r_state    <= EVAL;
          end else begin
            diff_reset <= 1'b0;
            r_state    <= RUN;
          end
        end
        EVAL: begin
          if (w_hit) begin
            found   <= 1'b1;
            tau_out <= r_tau;
            done    <= 1'b1;
            r_state <= FINISH;
          end else if (r_tau == MAX_TAU_L) begin
            found   <= 1'b0;
            tau_out <= {TAU_WIDTH{1'b0}};
            done    <= 1'b1;
            r_state <= FINISH;
          end else begin
            r_running_sum <= w_sum;
            r_tau         <= r_tau + {{(TAU_WIDTH-1){1'b0}}, 1'b1};
            diff_tau      <= r_tau + {{(TAU_WIDTH-1){1'b0}}, 1'b1};
            r_state       <= CLEAR;
          end
        end
        FINISH: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state    <= IDLE;
          busy       <= 1'b0;
          done       <= 1'b0;
          diff_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_yin_tau_scheduler.sv
// Scoreboard bench for yin_tau_scheduler with a behavioural difference
// datapath whose d(tau) values come from a per-test table.
module tb_yin_tau_scheduler;

  localparam int AW   = 64;
  localparam int MAXT = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] threshold;
  logic [5:0]  diff_tau;
  logic        diff_reset;
  logic        diff_ready;
  logic [63:0] diff_acc;
  logic        busy;
  logic        done;
  logic        found;
  logic [5:0]  tau_out;

  always #5 clk = ~clk;

  yin_tau_scheduler #(
    .WINDOW_SIZE_BITS (8),
    .ACC_WIDTH        (AW),
    .MAX_TAU          (MAXT),
    .THRESH_FRAC_BITS (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .threshold  (threshold),
    .diff_tau   (diff_tau),
    .diff_reset (diff_reset),
    .diff_ready (diff_ready),
    .diff_acc   (diff_acc),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .tau_out    (tau_out)
  );

  // Datapath model: latency varies with tau, output is garbage until ready.
  logic [63:0] dtab [64];
  logic        dp_ready = 1'b0;
  int          dp_cnt   = 0;

  always @(posedge clk) begin
    if (diff_reset) begin
      dp_cnt   <= 0;
      dp_ready <= 1'b0;
    end else if (dp_cnt >= 1 + int'(diff_tau % 6'd4)) begin
      dp_ready <= 1'b1;
    end else begin
      dp_cnt <= dp_cnt + 1;
    end
  end

  assign diff_ready = dp_ready;
  assign diff_acc   = dp_ready ? dtab[diff_tau] : 64'hFFFF_FFFF_FFFF_FFFF;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit       found;
    bit [5:0] tau;
    int       runs;
  } exp_t;

  exp_t sb[$];
  int   run_cnt = 0;
  logic prev_dr = 1'b1;

  // Monitor: checks the lag sequence on each RUN entry and scores each done.
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_dr && !diff_reset && busy) begin
        run_cnt++;
        chk("diff_tau_seq", 64'(diff_tau), 64'(run_cnt));
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd0, 64'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("found", 64'(found), 64'(e.found));
          chk("tau_out", 64'(tau_out), 64'(e.tau));
          chk("lags_run", 64'(run_cnt), 64'(e.runs));
        end
      end
    end
    prev_dr = diff_reset;
  end

  task automatic fill(input logic [63:0] v);
    for (int k = 0; k < 64; k++) dtab[k] = v;
  endtask

  task automatic push_exp(input bit f, input bit [5:0] t, input int r);
    exp_t e;
    e.found = f;
    e.tau   = t;
    e.runs  = r;
    sb.push_back(e);
  endtask

  // Independent reference: first lag with d*t < thr*S/2^16, S != 0.
  task automatic model(input logic [15:0] thr, output bit f, output bit [5:0] t, output int r);
    logic [127:0] sum;
    logic [127:0] s;
    f   = 1'b0;
    t   = 6'd0;
    r   = MAXT;
    sum = 128'd0;
    for (int k = 1; k <= MAXT; k++) begin
      s = sum + 128'(dtab[k]);
      if (s != 128'd0 && (128'(dtab[k]) * 128'(k) * 128'd65536) < (128'(thr) * s)) begin
        f = 1'b1;
        t = 6'(k);
        r = k;
        break;
      end
      sum = s;
    end
  endtask

  task automatic start_frame(input logic [15:0] thr, input bit f, input bit [5:0] t, input int r);
    threshold = thr;
    push_exp(f, t, r);
    run_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    threshold = 16'h0000;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("clear_diff_tau", 64'(diff_tau), 64'd1);
    chk("clear_diff_reset", 64'(diff_reset), 64'd1);
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (i == 3000) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_run(input int n);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (run_cnt == n && !diff_reset) break;
    end
    if (i == 3000) chk("run_timeout", 64'd0, 64'd1);
  endtask

  task automatic after_done();
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_diff_reset", 64'(diff_reset), 64'd1);
  endtask

  initial begin
    bit       mf;
    bit [5:0] mt;
    int       mr;

    reset     = 1'b1;
    start     = 1'b0;
    threshold = 16'h0000;
    fill(64'd1000);
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_found", 64'(found), 64'd0);
    chk("rst_tau_out", 64'(tau_out), 64'd0);
    chk("rst_diff_reset", 64'(diff_reset), 64'd1);
    chk("rst_diff_tau", 64'(diff_tau), 64'd0);

    // Start while reset is asserted must be dropped.
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("start_in_reset", 64'(busy), 64'd0);

    // No lag meets 0.5 when every d(tau) is equal.
    start_frame(16'h8000, 1'b0, 6'd0, MAXT);
    wait_done();
    after_done();

    // d(5)=100: S=4100, 500/4100 < 0.5.
    dtab[5] = 64'd100;
    start_frame(16'h8000, 1'b1, 6'd5, 5);
    wait_done();
    start = 1'b1;
    @(negedge clk);
    chk("start_in_done_ignored", 64'(busy), 64'd0);
    chk("found_held", 64'(found), 64'd1);
    chk("tau_out_held", 64'(tau_out), 64'd5);
    threshold = 16'h0000;
    push_exp(1'b0, 6'd0, MAXT);
    run_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    chk("accept_after_done", 64'(busy), 64'd1);
    chk("found_cleared", 64'(found), 64'd0);
    chk("tau_out_cleared", 64'(tau_out), 64'd0);
    // Zero threshold never hits; a start during RUN must not restart.
    wait_run(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    after_done();

    // All-zero differences: S stays zero, so no hit even at max threshold.
    fill(64'd0);
    start_frame(16'hFFFF, 1'b0, 6'd0, MAXT);
    wait_done();
    after_done();

    // Decreasing differences against a 0.25 threshold.
    for (int k = 0; k < 64; k++) dtab[k] = 64'(3000 - 60 * k);
    dtab[0] = 64'd0;
    model(16'h4000, mf, mt, mr);
    start_frame(16'h4000, mf, mt, mr);
    wait_done();
    after_done();

    // Reset during RUN at tau=3, then a clean restart from tau=1.
    fill(64'd1000);
    start_frame(16'h8000, 1'b0, 6'd0, MAXT);
    wait_run(3);
    chk("run_at_tau3", 64'(diff_tau), 64'd3);
    reset = 1'b1;
    @(negedge clk);
    chk("midrun_busy", 64'(busy), 64'd0);
    chk("midrun_diff_reset", 64'(diff_reset), 64'd1);
    chk("midrun_done", 64'(done), 64'd0);
    chk("midrun_diff_tau", 64'(diff_tau), 64'd0);
    sb.delete();
    reset = 1'b0;
    @(negedge clk);
    dtab[7] = 64'd10;
    start_frame(16'h8000, 1'b1, 6'd7, 7);
    wait_done();
    after_done();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
